// File: rtl/swap_pkg.sv
// Shared definitions for the swap stage and its downstream pair checker.
package swap_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int RUN_W     = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; sat flags the ceiling.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] out,
   output logic         sat
);

   logic [W-1:0] cnt_r;

   // count register: reset/clear to zero, otherwise increment below the ceiling
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (inc && !sat) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign out = cnt_r;
   assign sat = &cnt_r;

endmodule

// File: rtl/swap_pair_checker.sv
// Monitors a two-register swap stage: every new (a,b) sample must equal the
// previous sample exchanged. Counts good swaps/errors, tracks lock and fault.
module swap_pair_checker
   import swap_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_W     = 8,
   parameter int LOCK_N    = 4,
   parameter int ERR_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [CNT_W-1:0] swap_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             mismatch,
   output logic             locked,
   output logic             fault
);

   localparam logic [RUN_W-1:0] LOCK_V  = RUN_W'(LOCK_N);
   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(ERR_LIMIT);

   state_t             state_r, state_n;
   logic [WIDTH-1:0]   a_prev_r, a_prev_n;
   logic [WIDTH-1:0]   b_prev_r, b_prev_n;
   logic [RUN_W-1:0]   run_r, run_n;
   logic               mismatch_n, locked_n, fault_n;
   logic               swap_inc_s, err_inc_s;
   logic               swap_sat_s, err_sat_s;
   logic               match_s;
   logic [RUN_W-1:0]   run_inc_s;
   logic [CNT_W-1:0]   err_next_s;

   assign match_s    = (a_in == b_prev_r) && (b_in == a_prev_r);
   assign run_inc_s  = (run_r >= LOCK_V) ? run_r : run_r + RUN_W'(1);
   // err_cnt value after this mismatch is counted, honouring saturation
   assign err_next_s = err_sat_s ? err_cnt : err_cnt + CNT_W'(1);

   sat_counter #(.W(CNT_W)) u_swap_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (swap_inc_s),
      .out   (swap_cnt),
      .sat   (swap_sat_s)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (err_inc_s),
      .out   (err_cnt),
      .sat   (err_sat_s)
   );

   // state and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         a_prev_r <= '0;
         b_prev_r <= '0;
         run_r    <= '0;
         mismatch <= 1'b0;
         locked   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state_r  <= state_n;
         a_prev_r <= a_prev_n;
         b_prev_r <= b_prev_n;
         run_r    <= run_n;
         mismatch <= mismatch_n;
         locked   <= locked_n;
         fault    <= fault_n;
      end
   end

   // next-state, compare and counter-increment decode
   always_comb begin
      state_n    = state_r;
      a_prev_n   = a_prev_r;
      b_prev_n   = b_prev_r;
      run_n      = run_r;
      mismatch_n = 1'b0;
      locked_n   = locked;
      fault_n    = fault;
      swap_inc_s = 1'b0;
      err_inc_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (en) begin
               a_prev_n = a_in;
               b_prev_n = b_in;
               state_n  = S_CHECK;
            end else begin
               state_n  = S_IDLE;
            end
         end
         S_CHECK: begin
            if (en) begin
               // always resynchronise to the latest pair, good or bad
               a_prev_n = a_in;
               b_prev_n = b_in;
               if (match_s) begin
                  swap_inc_s = !swap_sat_s;
                  run_n      = run_inc_s;
                  locked_n   = (run_inc_s == LOCK_V) ? 1'b1 : locked;
               end else begin
                  mismatch_n = 1'b1;
                  err_inc_s  = 1'b1;
                  run_n      = '0;
                  locked_n   = 1'b0;
                  if (err_next_s >= LIMIT_V) begin
                     state_n = S_FAULT;
                     fault_n = 1'b1;
                  end else begin
                     state_n = S_CHECK;
                  end
               end
            end else begin
               state_n  = S_IDLE;
               run_n    = '0;
               locked_n = 1'b0;
            end
         end
         S_FAULT: begin
            state_n  = S_FAULT;
            fault_n  = 1'b1;
            locked_n = 1'b0;
         end
         default: begin
            state_n  = S_IDLE;
            run_n    = '0;
            locked_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_swap_pair_checker.sv
// Table-driven bench for swap_pair_checker with an expected-result queue.
module tb_swap_pair_checker;

   logic       clk = 1'b0;
   logic       rst_n, en;
   logic [3:0] a_in, b_in;
   logic [7:0] swap_cnt, err_cnt;
   logic       mismatch, locked, fault;

   logic       en2;
   logic [3:0] a2, b2;
   logic [1:0] swap2, err2;
   logic       mm2, lk2, ft2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   swap_pair_checker #(.WIDTH(4), .CNT_W(8), .LOCK_N(4), .ERR_LIMIT(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .swap_cnt(swap_cnt), .err_cnt(err_cnt), .mismatch(mismatch),
      .locked(locked), .fault(fault)
   );

   swap_pair_checker #(.WIDTH(4), .CNT_W(2), .LOCK_N(4), .ERR_LIMIT(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .en(en2), .a_in(a2), .b_in(b2),
      .swap_cnt(swap2), .err_cnt(err2), .mismatch(mm2),
      .locked(lk2), .fault(ft2)
   );

   typedef struct packed {
      logic [7:0] swap;
      logic [7:0] err;
      logic       mm;
      logic       lk;
      logic       ft;
   } exp_t;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [3:0] a;
      logic [3:0] b;
      exp_t       exp;
      string      name;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic void add(input logic r, input logic e, input logic [3:0] a,
                               input logic [3:0] b, input logic [7:0] s,
                               input logic [7:0] er, input logic mm, input logic lk,
                               input logic ft, input string nm);
      vec_t v;
      v.rst_n = r; v.en = e; v.a = a; v.b = b;
      v.exp   = {s, er, mm, lk, ft};
      v.name  = nm;
      vecs.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      exp_t got, want;
      @(negedge clk);
      rst_n = v.rst_n; en = v.en; a_in = v.a; b_in = v.b;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      got  = {swap_cnt, err_cnt, mismatch, locked, fault};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got swap=%0d err=%0d mm=%b lk=%b ft=%b, required swap=%0d err=%0d mm=%b lk=%b ft=%b",
                  v.name, got.swap, got.err, got.mm, got.lk, got.ft,
                  want.swap, want.err, want.mm, want.lk, want.ft);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; a_in = 4'd0; b_in = 4'd0;
      en2 = 1'b0; a2 = 4'd0; b2 = 4'd0;

      //   rst en  a      b      swap   err   mm    lk    ft    name
      add(1'b0, 1'b0, 4'd0, 4'd0, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "reset0");
      add(1'b0, 1'b0, 4'd0, 4'd0, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "reset1");
      // clean swap stream, lock after the 4th good swap
      add(1'b1, 1'b1, 4'd3, 4'd9, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "prime");
      add(1'b1, 1'b1, 4'd9, 4'd3, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, "swap1");
      add(1'b1, 1'b1, 4'd3, 4'd9, 8'd2,  8'd0, 1'b0, 1'b0, 1'b0, "swap2");
      add(1'b1, 1'b1, 4'd9, 4'd3, 8'd3,  8'd0, 1'b0, 1'b0, 1'b0, "swap3");
      add(1'b1, 1'b1, 4'd3, 4'd9, 8'd4,  8'd0, 1'b0, 1'b1, 1'b0, "swap4_lock");
      // repeated pair: single mismatch, lock lost, then relock
      add(1'b1, 1'b1, 4'd3, 4'd9, 8'd4,  8'd1, 1'b1, 1'b0, 1'b0, "err1");
      add(1'b1, 1'b1, 4'd9, 4'd3, 8'd5,  8'd1, 1'b0, 1'b0, 1'b0, "recover1");
      add(1'b1, 1'b1, 4'd3, 4'd9, 8'd6,  8'd1, 1'b0, 1'b0, 1'b0, "recover2");
      add(1'b1, 1'b1, 4'd9, 4'd3, 8'd7,  8'd1, 1'b0, 1'b0, 1'b0, "recover3");
      add(1'b1, 1'b1, 4'd3, 4'd9, 8'd8,  8'd1, 1'b0, 1'b1, 1'b0, "relock");
      // enable gap: counters hold, lock drops, first sample back only primes
      add(1'b1, 1'b0, 4'd0, 4'd0, 8'd8,  8'd1, 1'b0, 1'b0, 1'b0, "gap1");
      add(1'b1, 1'b0, 4'd2, 4'd2, 8'd8,  8'd1, 1'b0, 1'b0, 1'b0, "gap2");
      add(1'b1, 1'b0, 4'd4, 4'd8, 8'd8,  8'd1, 1'b0, 1'b0, 1'b0, "gap3");
      add(1'b1, 1'b1, 4'd7, 4'd1, 8'd8,  8'd1, 1'b0, 1'b0, 1'b0, "reprime");
      add(1'b1, 1'b1, 4'd1, 4'd7, 8'd9,  8'd1, 1'b0, 1'b0, 1'b0, "gap_swap");
      // degenerate equal pair
      add(1'b1, 1'b1, 4'd5, 4'd5, 8'd9,  8'd2, 1'b1, 1'b0, 1'b0, "err2");
      add(1'b1, 1'b1, 4'd5, 4'd5, 8'd10, 8'd2, 1'b0, 1'b0, 1'b0, "degen_ok");
      // third error: pulse and fault on the same edge, then frozen
      add(1'b1, 1'b1, 4'd5, 4'd6, 8'd10, 8'd3, 1'b1, 1'b0, 1'b1, "err3_fault");
      add(1'b1, 1'b1, 4'd6, 4'd5, 8'd10, 8'd3, 1'b0, 1'b0, 1'b1, "fault_frozen");
      add(1'b1, 1'b0, 4'd5, 4'd6, 8'd10, 8'd3, 1'b0, 1'b0, 1'b1, "fault_en0");
      add(1'b0, 1'b1, 4'd5, 4'd6, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "fault_reset");
      // fault from a fresh start with a constant non-swapped pair
      add(1'b1, 1'b1, 4'd5, 4'd6, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "f_prime");
      add(1'b1, 1'b1, 4'd5, 4'd6, 8'd0,  8'd1, 1'b1, 1'b0, 1'b0, "f_err1");
      add(1'b1, 1'b1, 4'd5, 4'd6, 8'd0,  8'd2, 1'b1, 1'b0, 1'b0, "f_err2");
      add(1'b1, 1'b1, 4'd5, 4'd6, 8'd0,  8'd3, 1'b1, 1'b0, 1'b1, "f_err3");
      add(1'b1, 1'b1, 4'd6, 4'd5, 8'd0,  8'd3, 1'b0, 1'b0, 1'b1, "f_frozen");
      add(1'b0, 1'b0, 4'd0, 4'd0, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "f_reset");
      // reset coinciding with a would-be mismatch
      add(1'b1, 1'b1, 4'd2, 4'd4, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "r_prime");
      add(1'b1, 1'b1, 4'd4, 4'd2, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, "r_swap");
      add(1'b0, 1'b1, 4'd4, 4'd2, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "r_reset_on_err");
      add(1'b1, 1'b1, 4'd4, 4'd2, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, "r_idle_prime");
      add(1'b1, 1'b1, 4'd2, 4'd4, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0, "r_swap_again");

      foreach (vecs[i]) apply(vecs[i]);

      // narrow counter: six good swaps must stick at 3
      for (int i = 0; i < 7; i++) begin
         logic [1:0] want_s;
         logic       want_l;
         @(negedge clk);
         en2 = 1'b1;
         a2  = (i % 2 == 1) ? 4'd9 : 4'd3;
         b2  = (i % 2 == 1) ? 4'd3 : 4'd9;
         @(posedge clk);
         #1;
         want_s = (i > 3) ? 2'd3 : 2'(i);
         want_l = (i >= 4);
         checks++;
         if (swap2 !== want_s || err2 !== 2'd0 || lk2 !== want_l || mm2 !== 1'b0 || ft2 !== 1'b0) begin
            failures++;
            $display("FAIL sat_step%0d: got swap=%0d err=%0d lk=%b mm=%b ft=%b, required swap=%0d err=0 lk=%b mm=0 ft=0",
                     i, swap2, err2, lk2, mm2, ft2, want_s, want_l);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/swap_pair_checker.md
Name: swap_pair_checker

Overview:
- Downstream consumer of the two-register swap stage. Samples its registered pair outputs (a, b) every clock and checks that each new pair is the previous pair exchanged.
- Counts good swaps and mismatches, reports lock after a run of consecutive good swaps, and latches a sticky fault after too many errors.
- Serves as the self-checking monitor stage in the blocking/non-blocking swap benches, and as a synthesizable health checker.

Parameters:
- WIDTH, 4, bit width of each data word (matches the swap stage's 4-bit a/b).
- CNT_W, 8, width of the swap and error counters.
- LOCK_N, 4, consecutive good swaps required to assert locked (range 1..15).
- ERR_LIMIT, 3, error count at which FAULT is entered (range 1..2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock, same clock as the swap stage.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  sample enable; 0 suspends checking.
- a_in  input  WIDTH  first word from the swap stage.
- b_in  input  WIDTH  second word from the swap stage.
- swap_cnt  output  CNT_W  saturating count of good swaps.
- err_cnt  output  CNT_W  saturating count of mismatches.
- mismatch  output  1  one-cycle pulse per detected mismatch.
- locked  output  1  high while at least LOCK_N consecutive good swaps have been seen.
- fault  output  1  sticky fault flag.

Behaviour:
- Reset and clocking:
  - Reset is synchronous and active-low. rst_n=0 at a rising clk edge: state=IDLE, a_prev=b_prev=0, swap_cnt=0, err_cnt=0, run_cnt=0, mismatch=0, locked=0, fault=0.
  - Reset overrides everything, including FAULT and any cycle mid-check.
  - All outputs are registered. A sample taken at edge N is reported after edge N (no combinational input-to-output path).
- States: IDLE, CHECK, FAULT.
- IDLE:
  - en=0: hold all regs; mismatch=0.
  - en=1: capture a_prev<=a_in, b_prev<=b_in, go to CHECK. No comparison on this first sample.
- CHECK, en=1: compare (a_in==b_prev) && (b_in==a_prev).
  - Match:
    - swap_cnt+1, saturating at all-ones.
    - run_cnt+1, saturating at LOCK_N.
    - locked<=1 when the incremented run_cnt reaches LOCK_N.
  - Mismatch:
    - mismatch<=1 for one cycle.
    - err_cnt+1, saturating.
    - run_cnt<=0, locked<=0.
    - If the incremented err_cnt >= ERR_LIMIT: go to FAULT, fault<=1.
  - a_prev/b_prev are always updated with the current sample, match or not. The checker resynchronises to the new pair.
- CHECK, en=0: go to IDLE; run_cnt<=0, locked<=0; counters hold. Re-entry re-primes from IDLE.
- FAULT:
  - fault=1, locked=0, mismatch=0; all counters frozen.
  - en is ignored; leave only via reset.
- Degenerate pair: a_prev==b_prev is still checked by the same rule and counts as a good swap when the pair is unchanged.
- Simultaneous events: reset beats everything. A mismatch that reaches ERR_LIMIT pulses mismatch and sets fault on the same edge.
- Widths: counters use unsigned CNT_W arithmetic. Saturation is checked before increment, with no wrap. run_cnt is 4 bits.

Decomposition:
- Shared package / include file `swap_pkg`:
  - State encoding constants S_IDLE=2'd0, S_CHECK=2'd1, S_FAULT=2'd2.
  - Default WIDTH=4, shared with the swap stage.
- One natural sub-module: `sat_counter` (parameterised width, inc, clr, out, sat flag). It is instantiated twice, for swap_cnt and err_cnt.
- Comparator and FSM stay in the top module.

Test Plan:
- Reset then clean swap: after rst_n released, en=1; drive (a,b)=(3,9),(9,3),(3,9),(9,3),(3,9). Required: swap_cnt=4; locked rises after the 4th good swap (edge following the 5th sample); err_cnt=0; mismatch never high.
- Single error: locked with (3,9)/(9,3) alternating, then inject (3,9) twice in a row. Required: one mismatch pulse, err_cnt=1, locked=0, run_cnt reset. Next correct (9,3) → swap_cnt increments and locking restarts.
- Fault entry: three non-swapped samples (5,6),(5,6),(5,6),(5,6) after priming. Required: err_cnt=3; fault=1 on the same edge as the third mismatch pulse. Further traffic leaves swap_cnt and err_cnt frozen. A rst_n=0 pulse clears everything to 0.
- Enable gap: mid-stream en=0 for 3 cycles, then en=1 with (7,1),(1,7). Required: counters held during the gap; locked=0; the first sample after the gap is not compared; (1,7) counts as one good swap.
- Saturation: CNT_W=2, run 6 good swaps. Required: swap_cnt sticks at 3, no wrap to 0.
- Reset mid-operation: assert rst_n=0 on the same edge as a mismatch. Required: mismatch=0, err_cnt=0, state=IDLE after that edge.
